adder_prefix_pipe: RTL
======================

ADDER_PREFIX_PIPE -- requirements
Module: adder_prefix_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/sum width, legal range 2..128, power of two not required.
REQ-002 SHALL have parameter PIPE_EVERY, default 2: prefix levels per pipeline register; 0 means no internal registers.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  operand beat present.
REQ-007 in_ready  output  1  block accepts beat this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in, used when sub=0.
REQ-011 sub  input  1  1 = compute a - b.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 sum  output  WIDTH  result bits.
REQ-015 cout  output  1  carry out of MSB; for sub, 1 = no borrow.
REQ-016 ovf  output  1  two's-complement signed overflow.

Function
REQ-017 SHALL compute {cout,sum} = a + b' + c, where b' = sub ? ~b : b and c = sub ? 1 : cin.
REQ-018 ovf SHALL be 1 iff a[MSB] == b'[MSB] and sum[MSB] != a[MSB].
REQ-019 Carry network SHALL be Kogge-Stone: LEVELS = clog2(WIDTH) levels, level k combining span 2^k, with (g,p) o (g',p') = (g | p&g', p&p').
REQ-020 Latency SHALL be LAT = 1 when PIPE_EVERY=0, else 1 + ceil(LEVELS/PIPE_EVERY) cycles from accepted input to out_valid.
REQ-021 Stage 0 SHALL register bitwise p, g, and the effective carry-in.
REQ-022 A register SHALL follow every PIPE_EVERY-th prefix level.
REQ-023 The final register SHALL hold sum, cout and ovf.
REQ-024 Per-bit p and the carry-in SHALL be carried alongside the group signals through all stages.
REQ-025 Each pipeline stage SHALL carry a valid bit.
REQ-026 Global advance enable SHALL be en = out_ready | ~out_valid.
REQ-027 in_ready SHALL equal en, combinationally.
REQ-028 An input beat SHALL be accepted iff in_valid & in_ready.
REQ-029 When en=0, every stage, including data and valid bits, SHALL hold.
REQ-030 Bubbles SHALL propagate as valid=0, with no collapsing.
REQ-031 sum/cout/ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-032 Results SHALL emerge in acceptance order, with no loss or duplication.
REQ-033 Throughput SHALL be one beat per cycle when out_ready=1.
REQ-034 Boundaries: all-ones + 1 gives sum 0, cout 1; a = b = 0 with cin=1 gives sum 1.
REQ-035 WIDTH not a power of two: missing high-span operands SHALL be treated as identity (g=0, p=1).

Reset
REQ-036 rst=1 SHALL asynchronously clear all stage valid bits.
REQ-037 rst=1 SHALL asynchronously clear out_valid, sum, cout and ovf to 0.
REQ-038 Reset mid-stream SHALL discard all in-flight beats; none emerge after deassertion.
REQ-039 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-040 Package adder_prefix_pkg SHALL hold the clog2 function and the pg_t struct {g,p}.
REQ-041 Package adder_prefix_pkg SHALL hold the latency function LAT(WIDTH, PIPE_EVERY) for bench use.
REQ-042 Sub-module adder_prefix_level SHALL implement one combinational Kogge-Stone row, parameterised by WIDTH and span.
REQ-043 The top SHALL instantiate adder_prefix_level in a generate loop and insert registers per PIPE_EVERY.

Verification
REQ-044 WIDTH=8, PIPE_EVERY=2 (LAT=3): a=0xFF, b=0x01, cin=0 accepted cycle 0 -> out_valid cycle 3, sum=0x00, cout=1, ovf=0.
REQ-045 WIDTH=8: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0; a=0x7F, b=0x01, sub=0 -> sum=0x80, ovf=1.
REQ-046 WIDTH=32, PIPE_EVERY=2 (LAT=4): 100 back-to-back random beats, out_ready=1 -> 100 results.
REQ-047 Same run: first result at cycle 4, one result per cycle, all matching the reference model.
REQ-048 Backpressure: stream 10 beats; out_ready=0 for cycles 5..9 -> in_ready=0 and outputs frozen over that window; all 10 results in order, none lost or duplicated.
REQ-049 Reset mid-stream: assert rst with 3 beats in flight -> out_valid=0 immediately; no stale result after release.
REQ-050 Reset mid-stream: after release, a fresh beat emerges at LAT.
REQ-051 WIDTH=13, PIPE_EVERY=0 (LAT=1): exhaustive-random 10k vectors incl. 0x1FFF+1 -> sum=0, cout=1.

Source files
------------

// File: rtl/adder_prefix_pkg.sv
// adder_prefix_pkg
//   Shared types and elaboration-time helpers for the pipelined Kogge-Stone adder.
//   pg_t             : (generate, propagate) pair for one bit or one bit group.
//   IDENTITY_PG      : operand that leaves a group unchanged under pg_combine.
//   clog2()          : ceiling log2, which gives the number of prefix levels.
//   lat()            : cycles from an accepted input beat to its result.
//   pg_combine()     : prefix operator (g,p) o (g',p') = (g | p&g', p&p').
//   is_reg_boundary(): whether a pipeline register follows prefix level k.
package adder_prefix_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    localparam pg_t IDENTITY_PG = '{g: 1'b0, p: 1'b1};

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned lat(input int unsigned width, input int unsigned pipe_every);
        int unsigned levels;
        levels = clog2(width);
        if (pipe_every == 0) begin
            return 1;
        end
        return 1 + (levels + pipe_every - 1) / pipe_every;
    endfunction

    function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
        pg_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

    // Boundary k sits after k prefix levels; boundary 0 is the operand stage. The register that
    // would follow the last level is merged into the output register, which is why k < levels.
    function automatic bit is_reg_boundary(input int k, input int levels, input int pipe_every);
        if (pipe_every <= 0) begin
            return 1'b0;
        end
        if (k == 0) begin
            return 1'b1;
        end
        return ((k % pipe_every) == 0) && (k < levels);
    endfunction

endpackage

// File: rtl/adder_prefix_level.sv
// adder_prefix_level
//   One combinational Kogge-Stone row. Bit i combines its group with the group SPAN bits below.
//   Bits whose lower operand would fall below bit 0 combine with the identity operand, so their
//   group passes through unchanged (this also covers widths that are not a power of two).
//   Parameters: WIDTH - number of bits; SPAN - distance to the lower operand (2^level).
//   Ports:      pg_i  - group (g,p) per bit entering the row
//               pg_o  - group (g,p) per bit leaving the row
module adder_prefix_level
    import adder_prefix_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SPAN  = 1
) (
    input  pg_t [WIDTH-1:0] pg_i,
    output pg_t [WIDTH-1:0] pg_o
);

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        if (i >= int'(SPAN)) begin : g_comb
            assign pg_o[i] = pg_combine(pg_i[i], pg_i[i - int'(SPAN)]);
        end else begin : g_pass
            assign pg_o[i] = pg_combine(pg_i[i], IDENTITY_PG);
        end
    end

endmodule

// File: rtl/adder_prefix_pipe.sv
// adder_prefix_pipe
//   Pipelined Kogge-Stone adder/subtractor with a valid/ready stream on both sides.
//   {cout,sum} = a + (sub ? ~b : b) + (sub ? 1 : cin); ovf flags two's-complement overflow.
//   A register follows the operand stage and every PIPE_EVERY-th prefix level; the final
//   register holds sum/cout/ovf. PIPE_EVERY = 0 leaves only the output register.
//   The whole pipe advances together on en = out_ready | ~out_valid, so bubbles are kept.
//   Ports:
//     clk, rst            - clock, asynchronous active-high reset
//     in_valid / in_ready - input beat handshake (in_ready == en)
//     a, b, cin, sub      - operands, carry-in (ignored when sub=1), subtract select
//     out_valid/out_ready - result beat handshake
//     sum, cout, ovf      - result, carry out of MSB (1 = no borrow for sub), signed overflow
module adder_prefix_pipe
    import adder_prefix_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned PIPE_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned LEVELS = clog2(WIDTH);

    // Everything a stage carries: valid, effective carry-in, per-bit p and group (g,p).
    typedef struct packed {
        logic             vld;
        logic             c0;
        logic [WIDTH-1:0] pb;
        pg_t  [WIDTH-1:0] pg;
    } stage_t;

    logic             en;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    assign en       = out_ready | ~out_valid_q;
    assign in_ready = en;

    // Operand stage: bitwise generate/propagate against the effective B operand.
    logic [WIDTH-1:0] b_eff;
    stage_t           stage0;

    always_comb begin
        b_eff      = sub ? ~b : b;
        stage0.vld = in_valid;
        stage0.c0  = sub | cin;
        stage0.pb  = a ^ b_eff;
        for (int i = 0; i < int'(WIDTH); i++) begin
            stage0.pg[i].g = a[i] & b_eff[i];
            stage0.pg[i].p = a[i] ^ b_eff[i];
        end
    end

    // Boundary k holds the stage after k prefix levels, registered or passed straight through.
    for (genvar k = 0; k <= int'(LEVELS); k++) begin : g_stage
        stage_t pre;
        stage_t post;

        if (k == 0) begin : g_first
            assign pre = stage0;
        end else begin : g_level
            pg_t [WIDTH-1:0] lvl_pg;

            adder_prefix_level #(
                .WIDTH (WIDTH),
                .SPAN  (2 ** (k - 1))
            ) u_level (
                .pg_i (g_stage[k-1].post.pg),
                .pg_o (lvl_pg)
            );

            assign pre = '{
                vld: g_stage[k-1].post.vld,
                c0:  g_stage[k-1].post.c0,
                pb:  g_stage[k-1].post.pb,
                pg:  lvl_pg
            };
        end

        if (is_reg_boundary(k, int'(LEVELS), int'(PIPE_EVERY))) begin : g_reg
            stage_t stage_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stage_q <= '0;
                end else if (en) begin
                    stage_q <= pre;
                end
            end

            assign post = stage_q;
        end else begin : g_wire
            assign post = pre;
        end
    end

    // After the last level every group spans [i:0], so each carry is G | P & c0.
    stage_t           fin;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;

    assign fin = g_stage[LEVELS].post;

    always_comb begin
        carry[0] = fin.c0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            carry[i+1] = fin.pg[i].g | (fin.pg[i].p & fin.c0);
        end
        sum_d  = fin.pb ^ carry[WIDTH-1:0];
        cout_d = carry[WIDTH];
        // Equal-sign operands flip the MSB exactly when carry-in and carry-out of the MSB differ.
        ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (en) begin
            out_valid_q <= fin.vld;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
